alveo_hls4ml_mul_share_arb: RTL and testbench

//  Shares one 4-stage signed 16x16->32 multiplier pipeline between NUM_REQ requesters.

---
 rtl/mul_share_arb_pkg.sv | 45 ++++
 rtl/alveo_hls4ml_mul_share_pipe.sv | 103 ++++++++++
 rtl/alveo_hls4ml_mul_share_arb.sv | 120 ++++++++++++
 tb/tb_alveo_hls4ml_mul_share_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the
// shared-multiplier arbiter.
package mul_share_arb_pkg;

    localparam int MUL_LAT = 4;
    localparam int MAX_REQ = 16;

    typedef logic signed [15:0] operand_t;
    typedef logic signed [31:0] product_t;

    // One-hot grant: first valid requester at or above ptr, wrapping n-1 -> 0.
    // Bits at or above n are always zero.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [3:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = {MAX_REQ{1'b0}};
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end else begin
                    idx = idx;
                end
                if (!found && valid[idx[3:0]]) begin
                    grant[idx[3:0]] = 1'b1;
                    found           = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                grant = grant;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/alveo_hls4ml_mul_share_pipe.sv
// Four-stage clock-enabled signed 16x16->32 multiplier with a parallel
// {valid,id} pipeline. Data and id registers only load behind a valid stage,
// so the output holds its last product while bubbles pass through.
module alveo_hls4ml_mul_share_pipe
    import mul_share_arb_pkg::*;
#(
    parameter int ID_W = 2
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    input  logic            ce,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    input  logic [15:0]     in_a,
    input  logic [15:0]     in_b,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [31:0]     out_p
);

    logic [MUL_LAT-2:0] vld_r;
    operand_t           a_r;
    operand_t           b_r;
    product_t           prod1_r;
    product_t           prod2_r;
    logic [ID_W-1:0]    id1_r;
    logic [ID_W-1:0]    id2_r;
    logic [ID_W-1:0]    id3_r;

    // Valid shift register; bubbles advance with the pipe and are never collapsed.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_r     <= {(MUL_LAT-1){1'b0}};
            out_valid <= 1'b0;
        end else if (ce) begin
            vld_r     <= {vld_r[MUL_LAT-3:0], in_valid};
            out_valid <= vld_r[MUL_LAT-2];
        end else begin
            vld_r     <= vld_r;
            out_valid <= out_valid;
        end
    end

    // Stage 1: capture the granted operand pair and its tag.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_r   <= 16'sd0;
            b_r   <= 16'sd0;
            id1_r <= {ID_W{1'b0}};
        end else if (ce && in_valid) begin
            a_r   <= operand_t'(in_a);
            b_r   <= operand_t'(in_b);
            id1_r <= in_id;
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            id1_r <= id1_r;
        end
    end

    // Stage 2: full-precision signed multiply.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            prod1_r <= 32'sd0;
            id2_r   <= {ID_W{1'b0}};
        end else if (ce && vld_r[0]) begin
            prod1_r <= product_t'(a_r) * product_t'(b_r);
            id2_r   <= id1_r;
        end else begin
            prod1_r <= prod1_r;
            id2_r   <= id2_r;
        end
    end

    // Stage 3: product retiming register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            prod2_r <= 32'sd0;
            id3_r   <= {ID_W{1'b0}};
        end else if (ce && vld_r[1]) begin
            prod2_r <= prod1_r;
            id3_r   <= id2_r;
        end else begin
            prod2_r <= prod2_r;
            id3_r   <= id3_r;
        end
    end

    // Stage 4: output register; holds the last result across bubbles and stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_p  <= 32'h0000_0000;
            out_id <= {ID_W{1'b0}};
        end else if (ce && vld_r[2]) begin
            out_p  <= prod2_r;
            out_id <= id3_r;
        end else begin
            out_p  <= out_p;
            out_id <= out_id;
        end
    end

endmodule

// File: rtl/alveo_hls4ml_mul_share_arb.sv
// Round-robin arbiter sharing one 4-stage signed multiplier between NUM_REQ
// requesters; results return tagged with the requester index under
// valid/ready backpressure.
// Optional build macro MUL_SHARE_ARB_PERF_EN adds saturating issue/stall
// counters with a synchronous clear.
module alveo_hls4ml_mul_share_arb
    import mul_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*16-1:0] req_a,
    input  logic [NUM_REQ*16-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [31:0]          res_p
`ifdef MUL_SHARE_ARB_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    logic               ce_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               issue_s;
    logic [ID_W-1:0]    sel_id_s;
    logic [15:0]        sel_a_s;
    logic [15:0]        sel_b_s;
    logic [ID_W-1:0]    rr_ptr_r;

    // Pipe advance enable, round-robin grant, accept strobes and operand mux.
    always_comb begin
        ce_s    = !(res_valid && !res_ready);
        grant_s = NUM_REQ'(rr_pick(MAX_REQ'(req_valid), 4'(rr_ptr_r), NUM_REQ));
        if (ap_rst_n && ce_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        issue_s  = |req_ready;
        sel_id_s = {ID_W{1'b0}};
        sel_a_s  = 16'h0000;
        sel_b_s  = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_id_s = ID_W'(i);
                sel_a_s  = req_a[16*i +: 16];
                sel_b_s  = req_b[16*i +: 16];
            end else begin
                sel_id_s = sel_id_s;
            end
        end
    end

    // Round-robin pointer moves just past the requester that transferred.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr_r <= {ID_W{1'b0}};
        end else if (issue_s) begin
            if (sel_id_s == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_r <= {ID_W{1'b0}};
            end else begin
                rr_ptr_r <= sel_id_s + ID_W'(1'b1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    alveo_hls4ml_mul_share_pipe #(
        .ID_W (ID_W)
    ) u_pipe (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ce        (ce_s),
        .in_valid  (issue_s),
        .in_id     (sel_id_s),
        .in_a      (sel_a_s),
        .in_b      (sel_b_s),
        .out_valid (res_valid),
        .out_id    (res_id),
        .out_p     (res_p)
    );

`ifdef MUL_SHARE_ARB_PERF_EN
    // Issue counter: one per transfer, saturating, clear wins over increment.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_issue_cnt <= 32'h0000_0000;
        end else if (perf_clr) begin
            perf_issue_cnt <= 32'h0000_0000;
        end else if (issue_s && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
        end else begin
            perf_issue_cnt <= perf_issue_cnt;
        end
    end

    // Stall counter: one per cycle with the pipe frozen, saturating.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_stall_cnt <= 32'h0000_0000;
        end else if (perf_clr) begin
            perf_stall_cnt <= 32'h0000_0000;
        end else if (!ce_s && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end else begin
            perf_stall_cnt <= perf_stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_alveo_hls4ml_mul_share_arb.sv
// Directed testbench for alveo_hls4ml_mul_share_arb (NUM_REQ=4).
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_alveo_hls4ml_mul_share_arb;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [31:0] res_p;
`ifdef MUL_SHARE_ARB_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 ap_clk = ~ap_clk;

    alveo_hls4ml_mul_share_arb #(
        .NUM_REQ (4),
        .ID_W    (2)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p)
`ifdef MUL_SHARE_ARB_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        req_valid = 4'hF;
        res_ready = 1'b1;
`ifdef MUL_SHARE_ARB_PERF_EN
        perf_clr  = 1'b0;
`endif
        req_a = 64'h0;
        req_b = 64'h0;
        for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 16'd10);
        repeat (3) @(negedge ap_clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL rst_res_id got=%0d exp=0", res_id); end
        checks++; if (res_p !== 32'h0) begin failures++; $display("FAIL rst_res_p got=%h exp=00000000", res_p); end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
        repeat (3) @(negedge ap_clk);
        @(negedge ap_clk);
        req_valid = 4'h0;
        repeat (6) @(negedge ap_clk);
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_rdy;
        logic        exp_v;
        logic [1:0]  exp_id;
        logic [31:0] exp_p;
        for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 16'd10);
        res_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge ap_clk);
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            exp_rdy = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            exp_v   = (k >= 4) && (k < 12);
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rot_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
            checks++; if (res_valid !== exp_v) begin failures++; $display("FAIL rot_valid k=%0d got=%b exp=%b", k, res_valid, exp_v); end
            if (exp_v) begin
                exp_id = 2'((k - 4) % 4);
                exp_p  = 32'((((k - 4) % 4) + 1) * 10);
                checks++; if ({res_id, res_p} !== {exp_id, exp_p}) begin failures++; $display("FAIL rot_data k=%0d got id=%0d p=%h exp id=%0d p=%h", k, res_id, res_p, exp_id, exp_p); end
            end
        end
    endtask

    task automatic test_arith();
        logic [3:0]  vin  [8] = '{4'h7, 4'h6, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [3:0]  erdy [8] = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic        ev   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]  eid  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
        logic [31:0] ep   [8] = '{32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h4000_0000, 32'hFFFF_EA61, 32'hC000_8000, 32'hC000_8000};
        set_ops(0, 16'h8000, 16'h8000);
        set_ops(1, 16'd123,  16'hFFD3);
        set_ops(2, 16'h7FFF, 16'h8000);
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            req_valid = vin[k];
            #1;
            checks++; if (req_ready !== erdy[k]) begin failures++; $display("FAIL arith_ready k=%0d got=%b exp=%b", k, req_ready, erdy[k]); end
            checks++; if (res_valid !== ev[k]) begin failures++; $display("FAIL arith_valid k=%0d got=%b exp=%b", k, res_valid, ev[k]); end
            if (k >= 4) begin
                checks++; if ({res_id, res_p} !== {eid[k], ep[k]}) begin failures++; $display("FAIL arith_data k=%0d got id=%0d p=%h exp id=%0d p=%h", k, res_id, res_p, eid[k], ep[k]); end
            end
        end
    endtask

    task automatic test_wrap_sparse();
        logic [3:0]  vin  [10] = '{4'h8, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic        ev   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]  eid  [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [31:0] ep   [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h1,
                                   32'h2A, 32'hFFFF_FFD6, 32'h2710, 32'h2710};
        res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge ap_clk);
            if (k == 0) set_ops(3, 16'hFFFF, 16'hFFFF);
            if (k == 2) set_ops(0, 16'd7, 16'd6);
            if (k == 3) set_ops(0, 16'hFFF9, 16'd6);
            if (k == 4) set_ops(0, 16'd100, 16'd100);
            req_valid = vin[k];
            #1;
            checks++; if (req_ready !== vin[k]) begin failures++; $display("FAIL wrap_ready k=%0d got=%b exp=%b", k, req_ready, vin[k]); end
            checks++; if (res_valid !== ev[k]) begin failures++; $display("FAIL wrap_valid k=%0d got=%b exp=%b", k, res_valid, ev[k]); end
            if (k >= 4) begin
                checks++; if ({res_id, res_p} !== {eid[k], ep[k]}) begin failures++; $display("FAIL wrap_data k=%0d got id=%0d p=%h exp id=%0d p=%h", k, res_id, res_p, eid[k], ep[k]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0]  vin  [14] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                   4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic        rr   [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  erdy [14] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h4,
                                   4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic        ev   [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]  eid  [14] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                   2'd3, 2'd0, 2'd1, 2'd2, 2'd2};
        logic [31:0] ep   [14] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd2000, 32'd3000, 32'd3000,
                                   32'd3000, 32'd3000, 32'd4000, 32'd1000, 32'd2000,
                                   32'd3000, 32'd3000};
        for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 16'd1000);
        for (int k = 0; k < 14; k++) begin
            @(negedge ap_clk);
            req_valid = vin[k];
            res_ready = rr[k];
            #1;
            checks++; if (req_ready !== erdy[k]) begin failures++; $display("FAIL stall_ready k=%0d got=%b exp=%b", k, req_ready, erdy[k]); end
            checks++; if (res_valid !== ev[k]) begin failures++; $display("FAIL stall_valid k=%0d got=%b exp=%b", k, res_valid, ev[k]); end
            if (k >= 4) begin
                checks++; if ({res_id, res_p} !== {eid[k], ep[k]}) begin failures++; $display("FAIL stall_data k=%0d got id=%0d p=%h exp id=%0d p=%h", k, res_id, res_p, eid[k], ep[k]); end
            end
        end
        res_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        logic [3:0] erdy [3] = '{4'h8, 4'h1, 4'h2};
        for (int k = 0; k < 3; k++) begin
            @(negedge ap_clk);
            req_valid = 4'hF;
            #1;
            checks++; if (req_ready !== erdy[k]) begin failures++; $display("FAIL flight_issue k=%0d got=%b exp=%b", k, req_ready, erdy[k]); end
        end
        @(negedge ap_clk);
`ifdef MUL_SHARE_ARB_PERF_EN
        checks++; if (perf_issue_cnt !== 32'd28) begin failures++; $display("FAIL perf_issue got=%0d exp=28", perf_issue_cnt); end
        checks++; if (perf_stall_cnt !== 32'd3) begin failures++; $display("FAIL perf_stall got=%0d exp=3", perf_stall_cnt); end
`endif
        ap_rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL flight_rst_ready got=%b exp=0000", req_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL flight_rst_valid got=%b exp=0", res_valid); end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        req_valid = 4'h0;
        #1;
`ifdef MUL_SHARE_ARB_PERF_EN
        checks++; if ({perf_issue_cnt, perf_stall_cnt} !== 64'h0) begin failures++; $display("FAIL perf_after_rst got issue=%0d stall=%0d exp=0,0", perf_issue_cnt, perf_stall_cnt); end
`endif
        for (int k = 0; k < 8; k++) begin
            checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL flight_ghost k=%0d got=%b exp=0", k, res_valid); end
            @(negedge ap_clk);
            #1;
        end
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL flight_regrant got=%b exp=0001", req_ready); end
        @(negedge ap_clk);
        req_valid = 4'h0;
`ifdef MUL_SHARE_ARB_PERF_EN
        perf_clr = 1'b1;
        @(negedge ap_clk);
        perf_clr = 1'b0;
        #1;
        checks++; if (perf_issue_cnt !== 32'd0) begin failures++; $display("FAIL perf_clr got=%0d exp=0", perf_issue_cnt); end
`endif
        repeat (6) @(negedge ap_clk);
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_arith();
        test_wrap_sparse();
        test_stall();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
